dbg_mode_ctrl: RTL and testbench
================================

# dbg_mode_ctrl

Debug-mode entry/exit controller: the consumer of the hardware-trigger `breakpoint` request and of the other halt sources (ebreak, debug-module haltreq, single step). It sequences pipeline flush and redirect to the debug ROM, owns `dbg_mode`, captures `dpc` and `dcsr.cause`, and handles resume back to `dpc`. It sits in the core beside the CSR file; its `dbg_mode` output feeds back into the trigger logic to suppress re-triggering.

## Interface
- `ADDR_WIDTH`, 32, PC/address width
- `DBG_ROM_ADDR`, 32'h0000_0800, debug ROM entry PC
- `cpu_clk`  in  1  core clock; all state on rising edge
- `cpu_rst`  in  1  asynchronous, active-high reset
- `breakpoint`  in  1  trigger hit on instruction in EX, level, valid only while `dbg_mode`=0
- `ebreak_ex`  in  1  ebreak in EX
- `dcsr_ebreakm`  in  1  ebreak enters debug mode when 1
- `dcsr_step`  in  1  single-step enable
- `haltreq`  in  1  level halt request from debug module
- `resumereq`  in  1  one-cycle resume request from debug module
- `dret_ex`  in  1  dret executed in EX (debug ROM)
- `pc_ex`  in  ADDR_WIDTH  PC of the instruction in EX
- `pc_next`  in  ADDR_WIDTH  PC following the instruction retiring this cycle
- `instr_retire`  in  1  one instruction retires this cycle
- `pipe_idle`  in  1  pipeline drained, no outstanding bus transaction
- `dpc_wr_en`  in  1  CSR write to dpc, honoured only in HALTED
- `dpc_wr_data`  in  ADDR_WIDTH  dpc write data
- `dbg_mode`  out  1  core in debug mode
- `halted`  out  1  state is HALTED
- `flush`  out  1  one-cycle pipeline kill
- `redirect_valid`  out  1  one-cycle fetch redirect
- `redirect_pc`  out  ADDR_WIDTH  redirect target
- `resumeack`  out  1  one-cycle acknowledge of resume
- `dpc`  out  ADDR_WIDTH  debug PC
- `dcsr_cause`  out  3  last entry cause: 1 ebreak, 2 trigger, 3 haltreq, 4 step

## Operation
- States: RUN, STEP, FLUSH, HALTED, RESUME.
- Entry detection (RUN or STEP), priority high→low: `breakpoint` (cause 2, dpc←`pc_ex`), `ebreak_ex && dcsr_ebreakm` (cause 1, dpc←`pc_ex`), `haltreq` (cause 3, dpc←`pc_ex`), STEP only: `instr_retire` (cause 4, dpc←`pc_next`). Any entry → FLUSH.
- FLUSH: hold until `pipe_idle`; then redirect to `DBG_ROM_ADDR`, → HALTED.
- HALTED: `dpc_wr_en` updates dpc. `resumereq` or `dret_ex` with `haltreq`=0 → RESUME. If `haltreq`=1 the resume is dropped (stay HALTED, no resumeack).
- RESUME (one cycle): redirect to `dpc`, pulse `resumeack`, clear `dbg_mode`; → STEP if `dcsr_step`, else RUN.
- `breakpoint`, `ebreak_ex`, `haltreq` ignored in FLUSH/HALTED/RESUME.
- `dcsr_cause`/`dpc` change only on entry or dpc write.

## Timing
- All outputs registered. Reset: state RUN; `dbg_mode`, `halted`, `flush`, `redirect_valid`, `resumeack` = 0; `redirect_pc`, `dpc` = 0; `dcsr_cause` = 0.
- Entry condition at edge N → at N+1: `flush`=1 (one cycle), `dbg_mode`=1, dpc/cause updated, state FLUSH.
- `pipe_idle` seen in FLUSH at edge M → at M+1: `redirect_valid`=1, `redirect_pc`=`DBG_ROM_ADDR`, `halted`=1. Minimum entry latency 2 cycles.
- Resume accepted at edge K → at K+1: state RESUME, `redirect_valid`=1, `redirect_pc`=dpc, `resumeack`=1, `dbg_mode`=0, `halted`=0; at K+2 RUN/STEP.
- `dpc_wr_en` and resume in same cycle: write takes effect, redirect uses the new value.
- STEP with `breakpoint` and `instr_retire` together: trigger wins, cause 2.
- Reset asserted in any state: immediate return to reset values; no partial redirect.

## Structure
- Cause codes (1–4), state encoding and `DBG_ROM_ADDR` default go in `dbg_defines.vh`; widths from `core_defines.vh`.
- One combinational sub-module natural: `dbg_cause_arb` (priority encode of entry sources → enter, cause, dpc source).

## Test plan
- `breakpoint`=1, `pc_ex`=0x104 in RUN, `pipe_idle` 3 cycles later → flush pulse at N+1, dpc=0x104, cause=2, redirect to 0x800, `halted`=1.
- `ebreak_ex`=1 with `dcsr_ebreakm`=0 → no entry; with 1 → cause=1, dpc=`pc_ex`.
- HALTED, `dpc_wr_en` 0x200, `resumereq` → redirect_pc=0x200, `resumeack` one cycle, `dbg_mode`=0, RUN.
- `dcsr_step`=1 resume, retire with `pc_next`=0x204 → cause=4, dpc=0x204, back to HALTED.
- `haltreq`=1 with `resumereq` in HALTED → stays HALTED, no `resumeack`; simultaneous `breakpoint`+`haltreq` in RUN → cause=2.
- `cpu_rst` pulsed in FLUSH → all outputs reset values, RUN, no redirect.

Source files
------------

// File: rtl/dbg_mode_ctrl_pkg.sv
// dbg_mode_ctrl_pkg
//   Shared definitions for the debug-mode entry/exit controller:
//   FSM state encoding, dcsr.cause codes and default parameters.
package dbg_mode_ctrl_pkg;

  localparam int          DBG_ADDR_WIDTH_DEFAULT = 32;
  localparam logic [31:0] DBG_ROM_ADDR_DEFAULT   = 32'h0000_0800;

  typedef enum logic [2:0] {
    ST_RUN    = 3'd0,
    ST_STEP   = 3'd1,
    ST_FLUSH  = 3'd2,
    ST_HALTED = 3'd3,
    ST_RESUME = 3'd4
  } dbg_state_e;

  // Encoding matches the architectural dcsr.cause field.
  typedef enum logic [2:0] {
    CAUSE_NONE    = 3'd0,
    CAUSE_EBREAK  = 3'd1,
    CAUSE_TRIGGER = 3'd2,
    CAUSE_HALTREQ = 3'd3,
    CAUSE_STEP    = 3'd4
  } dbg_cause_e;

endpackage

// File: rtl/dbg_mode_ctrl_cause_arb.sv
// dbg_mode_ctrl_cause_arb
//   Combinational priority encoder of debug-mode entry sources.
//   Ports:
//     detect_en     - controller is in RUN or STEP (entry sources are live)
//     step_mode     - controller is in STEP (retire counts as a halt source)
//     breakpoint, ebreak_ex, dcsr_ebreakm, haltreq, instr_retire - sources
//     enter         - some entry condition is present this cycle
//     cause         - winning cause code
//     use_pc_next   - dpc must capture pc_next instead of pc_ex
module dbg_mode_ctrl_cause_arb
  import dbg_mode_ctrl_pkg::*;
(
  input  logic       detect_en,
  input  logic       step_mode,
  input  logic       breakpoint,
  input  logic       ebreak_ex,
  input  logic       dcsr_ebreakm,
  input  logic       haltreq,
  input  logic       instr_retire,
  output logic       enter,
  output dbg_cause_e cause,
  output logic       use_pc_next
);

  // NOTE: every output gets a default before the priority chain so no path
  // leaves a signal unassigned; that is what keeps this block latch-free.
  always_comb begin
    enter       = 1'b0;
    cause       = CAUSE_NONE;
    use_pc_next = 1'b0;
    if (detect_en) begin
      // Trigger outranks everything, including a step retiring in the same
      // cycle: the triggering instruction must not execute.
      if (breakpoint) begin
        enter = 1'b1;
        cause = CAUSE_TRIGGER;
      end else if (ebreak_ex && dcsr_ebreakm) begin
        enter = 1'b1;
        cause = CAUSE_EBREAK;
      end else if (haltreq) begin
        enter = 1'b1;
        cause = CAUSE_HALTREQ;
      end else if (step_mode && instr_retire) begin
        enter       = 1'b1;
        cause       = CAUSE_STEP;
        use_pc_next = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dbg_mode_ctrl.sv
// dbg_mode_ctrl
//   Debug-mode entry/exit controller. Arbitrates halt sources, flushes the
//   pipeline, redirects fetch to the debug ROM, owns dbg_mode, captures dpc
//   and dcsr.cause, and resumes execution at dpc.
//   Ports:
//     cpu_clk, cpu_rst           - core clock, async active-high reset
//     breakpoint, ebreak_ex, dcsr_ebreakm, haltreq, dcsr_step - halt sources
//     resumereq, dret_ex         - resume sources
//     pc_ex, pc_next, instr_retire, pipe_idle - pipeline status
//     dpc_wr_en, dpc_wr_data     - CSR write port to dpc (HALTED only)
//     dbg_mode, halted           - mode/state indications
//     flush, redirect_valid, redirect_pc, resumeack - one-cycle pulses
//     dpc, dcsr_cause            - debug CSR contents
module dbg_mode_ctrl
  import dbg_mode_ctrl_pkg::*;
#(
  parameter int                    ADDR_WIDTH   = DBG_ADDR_WIDTH_DEFAULT,
  parameter logic [ADDR_WIDTH-1:0] DBG_ROM_ADDR = DBG_ROM_ADDR_DEFAULT[ADDR_WIDTH-1:0]
) (
  input  logic                  cpu_clk,
  input  logic                  cpu_rst,
  input  logic                  breakpoint,
  input  logic                  ebreak_ex,
  input  logic                  dcsr_ebreakm,
  input  logic                  dcsr_step,
  input  logic                  haltreq,
  input  logic                  resumereq,
  input  logic                  dret_ex,
  input  logic [ADDR_WIDTH-1:0] pc_ex,
  input  logic [ADDR_WIDTH-1:0] pc_next,
  input  logic                  instr_retire,
  input  logic                  pipe_idle,
  input  logic                  dpc_wr_en,
  input  logic [ADDR_WIDTH-1:0] dpc_wr_data,
  output logic                  dbg_mode,
  output logic                  halted,
  output logic                  flush,
  output logic                  redirect_valid,
  output logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  resumeack,
  output logic [ADDR_WIDTH-1:0] dpc,
  output logic [2:0]            dcsr_cause
);

  dbg_state_e state;
  logic       enter;
  dbg_cause_e arb_cause;
  logic       use_pc_next;
  logic       resume_ok;

  dbg_mode_ctrl_cause_arb u_cause_arb (
    .detect_en    (state == ST_RUN || state == ST_STEP),
    .step_mode    (state == ST_STEP),
    .breakpoint   (breakpoint),
    .ebreak_ex    (ebreak_ex),
    .dcsr_ebreakm (dcsr_ebreakm),
    .haltreq      (haltreq),
    .instr_retire (instr_retire),
    .enter        (enter),
    .cause        (arb_cause),
    .use_pc_next  (use_pc_next)
  );

  // A pending halt request wins over a resume; the resume is simply dropped.
  assign resume_ok = (resumereq || dret_ex) && !haltreq;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      state          <= ST_RUN;
      dbg_mode       <= 1'b0;
      halted         <= 1'b0;
      flush          <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      resumeack      <= 1'b0;
      dpc            <= '0;
      dcsr_cause     <= CAUSE_NONE;
    end else begin
      // Pulse outputs fall back to zero unless re-asserted below.
      flush          <= 1'b0;
      redirect_valid <= 1'b0;
      resumeack      <= 1'b0;
      unique case (state)
        ST_RUN, ST_STEP: begin
          if (enter) begin
            state      <= ST_FLUSH;
            flush      <= 1'b1;
            dbg_mode   <= 1'b1;
            dcsr_cause <= arb_cause;
            dpc        <= use_pc_next ? pc_next : pc_ex;
          end
        end
        ST_FLUSH: begin
          if (pipe_idle) begin
            state          <= ST_HALTED;
            redirect_valid <= 1'b1;
            redirect_pc    <= DBG_ROM_ADDR;
            halted         <= 1'b1;
          end
        end
        ST_HALTED: begin
          if (dpc_wr_en) begin
            dpc <= dpc_wr_data;
          end
          if (resume_ok) begin
            state          <= ST_RESUME;
            redirect_valid <= 1'b1;
            // Bypass so a same-cycle dpc write is the resume target.
            redirect_pc    <= dpc_wr_en ? dpc_wr_data : dpc;
            resumeack      <= 1'b1;
            dbg_mode       <= 1'b0;
            halted         <= 1'b0;
          end
        end
        ST_RESUME: begin
          state <= dcsr_step ? ST_STEP : ST_RUN;
        end
        default: begin
          state <= ST_RUN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dbg_mode_ctrl.sv
// tb_dbg_mode_ctrl
//   Directed self-checking bench for dbg_mode_ctrl. Inputs are driven 1 ns
//   after a rising edge; outputs are sampled at that same point.
module tb_dbg_mode_ctrl;

  localparam int AW = 32;

  logic          cpu_clk = 1'b0;
  logic          cpu_rst;
  logic          breakpoint, ebreak_ex, dcsr_ebreakm, dcsr_step;
  logic          haltreq, resumereq, dret_ex;
  logic [AW-1:0] pc_ex, pc_next, dpc_wr_data;
  logic          instr_retire, pipe_idle, dpc_wr_en;
  logic          dbg_mode, halted, flush, redirect_valid, resumeack;
  logic [AW-1:0] redirect_pc, dpc;
  logic [2:0]    dcsr_cause;

  int tests = 0;
  int fails = 0;

  dbg_mode_ctrl #(.ADDR_WIDTH(AW), .DBG_ROM_ADDR(32'h0000_0800)) dut (
    .cpu_clk        (cpu_clk),
    .cpu_rst        (cpu_rst),
    .breakpoint     (breakpoint),
    .ebreak_ex      (ebreak_ex),
    .dcsr_ebreakm   (dcsr_ebreakm),
    .dcsr_step      (dcsr_step),
    .haltreq        (haltreq),
    .resumereq      (resumereq),
    .dret_ex        (dret_ex),
    .pc_ex          (pc_ex),
    .pc_next        (pc_next),
    .instr_retire   (instr_retire),
    .pipe_idle      (pipe_idle),
    .dpc_wr_en      (dpc_wr_en),
    .dpc_wr_data    (dpc_wr_data),
    .dbg_mode       (dbg_mode),
    .halted         (halted),
    .flush          (flush),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .resumeack      (resumeack),
    .dpc            (dpc),
    .dcsr_cause     (dcsr_cause)
  );

  always #5 cpu_clk = ~cpu_clk;

  task automatic step();
    @(posedge cpu_clk);
    #1;
  endtask

  task automatic clear_inputs();
    breakpoint = 0; ebreak_ex = 0; dcsr_ebreakm = 0; dcsr_step = 0;
    haltreq = 0; resumereq = 0; dret_ex = 0; instr_retire = 0;
    pipe_idle = 0; dpc_wr_en = 0;
    pc_ex = '0; pc_next = '0; dpc_wr_data = '0;
  endtask

  // Compare the one-cycle pulse group plus mode flags in one go.
  task automatic expect_flags(input string name, input logic e_flush,
                              input logic e_rv, input logic e_ack,
                              input logic e_dbg, input logic e_halt);
    logic [4:0] got, want;
    got  = {flush, redirect_valid, resumeack, dbg_mode, halted};
    want = {e_flush, e_rv, e_ack, e_dbg, e_halt};
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s flags{flush,rv,ack,dbg,halt}: got %b want %b", name, got, want);
    end
  endtask

  task automatic expect_csr(input string name, input logic [AW-1:0] e_dpc,
                            input logic [2:0] e_cause);
    tests++;
    if (dpc !== e_dpc || dcsr_cause !== e_cause) begin
      fails++;
      $display("FAIL %s dpc/cause: got %h/%0d want %h/%0d", name, dpc, dcsr_cause, e_dpc, e_cause);
    end
  endtask

  task automatic expect_redirect(input string name, input logic [AW-1:0] e_pc);
    tests++;
    if (redirect_valid !== 1'b1 || redirect_pc !== e_pc) begin
      fails++;
      $display("FAIL %s redirect: got v=%b pc=%h want v=1 pc=%h", name, redirect_valid, redirect_pc, e_pc);
    end
  endtask

  // Drain FLUSH with pipe_idle and check the debug ROM redirect.
  task automatic drain_to_halted(input string name);
    pipe_idle = 1;
    step();
    pipe_idle = 0;
    expect_redirect(name, 32'h0000_0800);
    expect_flags(name, 0, 1, 0, 1, 1);
  endtask

  task automatic test_reset();
    clear_inputs();
    cpu_rst = 1;
    step();
    step();
    expect_flags("reset", 0, 0, 0, 0, 0);
    tests++;
    if (redirect_pc !== '0 || dpc !== '0 || dcsr_cause !== 3'd0) begin
      fails++;
      $display("FAIL reset regs: got rpc=%h dpc=%h cause=%0d want 0/0/0", redirect_pc, dpc, dcsr_cause);
    end
    cpu_rst = 0;
    step();
    expect_flags("reset_release", 0, 0, 0, 0, 0);
  endtask

  task automatic test_breakpoint_entry();
    breakpoint = 1; pc_ex = 32'h104;
    step();
    expect_flags("bp_entry", 1, 0, 0, 1, 0);
    expect_csr("bp_entry", 32'h104, 3'd2);
    // Still asserted in FLUSH with a new PC: must be ignored.
    pc_ex = 32'h999;
    step();
    breakpoint = 0;
    expect_flags("bp_flush_hold", 0, 0, 0, 1, 0);
    expect_csr("bp_flush_hold", 32'h104, 3'd2);
    step();
    drain_to_halted("bp_halt");
    step();
    expect_flags("bp_halted_idle", 0, 0, 0, 1, 1);
  endtask

  task automatic test_resume_with_dpc_write();
    dpc_wr_en = 1; dpc_wr_data = 32'h200; resumereq = 1;
    step();
    dpc_wr_en = 0; resumereq = 0;
    expect_redirect("resume_wr", 32'h200);
    expect_flags("resume_wr", 0, 1, 1, 0, 0);
    expect_csr("resume_wr", 32'h200, 3'd2);
    step();
    expect_flags("resume_wr_after", 0, 0, 0, 0, 0);
    // Back in RUN: retire alone must not halt outside STEP.
    instr_retire = 1; pc_next = 32'h208;
    step();
    instr_retire = 0;
    expect_flags("run_no_step", 0, 0, 0, 0, 0);
  endtask

  task automatic test_ebreak();
    ebreak_ex = 1; dcsr_ebreakm = 0; pc_ex = 32'h300;
    step();
    expect_flags("ebreak_m0", 0, 0, 0, 0, 0);
    expect_csr("ebreak_m0", 32'h200, 3'd2);
    dcsr_ebreakm = 1;
    step();
    ebreak_ex = 0;
    expect_flags("ebreak_m1", 1, 0, 0, 1, 0);
    expect_csr("ebreak_m1", 32'h300, 3'd1);
    drain_to_halted("ebreak_halt");
  endtask

  task automatic test_single_step();
    dcsr_step = 1; dret_ex = 1;
    step();
    dret_ex = 0;
    expect_redirect("step_resume", 32'h300);
    expect_flags("step_resume", 0, 1, 1, 0, 0);
    step();  // RESUME -> STEP
    instr_retire = 1; pc_next = 32'h204; pc_ex = 32'h300;
    step();
    instr_retire = 0;
    expect_flags("step_entry", 1, 0, 0, 1, 0);
    expect_csr("step_entry", 32'h204, 3'd4);
    drain_to_halted("step_halt");
  endtask

  task automatic test_haltreq_blocks_resume();
    haltreq = 1; resumereq = 1;
    step();
    resumereq = 0;
    expect_flags("haltreq_drop", 0, 0, 0, 1, 1);
    step();
    haltreq = 0;
    expect_flags("haltreq_drop2", 0, 0, 0, 1, 1);
    expect_csr("haltreq_drop", 32'h204, 3'd4);
  endtask

  task automatic test_step_trigger_priority();
    resumereq = 1;  // dcsr_step still 1
    step();
    resumereq = 0;
    expect_redirect("prio_resume", 32'h204);
    step();
    breakpoint = 1; instr_retire = 1; pc_ex = 32'h400; pc_next = 32'h404;
    step();
    breakpoint = 0; instr_retire = 0;
    expect_flags("step_bp_prio", 1, 0, 0, 1, 0);
    expect_csr("step_bp_prio", 32'h400, 3'd2);
    drain_to_halted("step_bp_halt");
  endtask

  task automatic test_run_trigger_priority();
    dcsr_step = 0; resumereq = 1;
    step();
    resumereq = 0;
    expect_redirect("run_resume", 32'h400);
    step();
    breakpoint = 1; haltreq = 1; pc_ex = 32'h500;
    step();
    breakpoint = 0; haltreq = 0;
    expect_flags("run_bp_haltreq", 1, 0, 0, 1, 0);
    expect_csr("run_bp_haltreq", 32'h500, 3'd2);
  endtask

  // Controller is in FLUSH on entry to this task.
  task automatic test_reset_in_flush();
    cpu_rst = 1;
    #1;
    expect_flags("rst_async", 0, 0, 0, 0, 0);
    expect_csr("rst_async", 32'h0, 3'd0);
    pipe_idle = 1;
    step();
    cpu_rst = 0;
    step();
    pipe_idle = 0;
    expect_flags("rst_no_redirect", 0, 0, 0, 0, 0);
    // haltreq from RUN must enter again, proving state is RUN.
    haltreq = 1; pc_ex = 32'h600;
    step();
    haltreq = 0;
    expect_flags("rst_then_haltreq", 1, 0, 0, 1, 0);
    expect_csr("rst_then_haltreq", 32'h600, 3'd3);
  endtask

  initial begin
    test_reset();
    test_breakpoint_entry();
    test_resume_with_dpc_write();
    test_ebreak();
    test_single_step();
    test_haltreq_blocks_resume();
    test_step_trigger_priority();
    test_run_trigger_priority();
    test_reset_in_flush();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
